alu_arb_seq: RTL and testbench

ALU_ARB_SEQ -- requirements
Module: alu_arb_seq

---
 rtl/alu_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/alu_arb_seq.sv | 121 ++++++++++++
 tb/tb_alu_arb_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, ALU opcode encodings and sequencer state type for the
// arbitrated ALU sequencer.
package alu_pkg;

   localparam int DATA_W = 8;
   localparam int OP_W   = 3;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_INC = 3'b110;
   localparam logic [2:0] OP_DEC = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the tie-break pointer moves only when the
// caller signals that the current grant was taken.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant,
   output logic       grant_id
);

   // prio_q high means requester 1 wins a tie
   logic prio_q;

   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = prio_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   assign grant_id = grant[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prio_q <= 1'b0;
      else if (update)
         prio_q <= ~grant_id;
   end

endmodule

// File: rtl/alu_arb_seq.sv
// Arbitrated front end for one external combinational ALU: accept, execute,
// respond. Define ALU_ARB_SEQ_FLAGS_EN to build the architectural flag register.
module alu_arb_seq #(
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int OP_W   = alu_pkg::OP_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*OP_W-1:0]   req_op,
   input  logic [2*DATA_W-1:0] req_a,
   input  logic [2*DATA_W-1:0] req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic [DATA_W-1:0]   rsp_result,
   output logic                rsp_carry,
   output logic                rsp_zero,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [OP_W-1:0]     alu_op,
   input  logic [DATA_W-1:0]   alu_result,
   input  logic                alu_carry,
   input  logic                alu_zero,
   output logic                flag_carry,
   output logic                flag_zero,
   output logic                busy
);

   import alu_pkg::*;

   state_t     state, state_nxt;
   logic [1:0] grant;
   logic       grant_id;
   logic       accept;

   assign accept = |(req_valid & req_ready);

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_valid),
      .update   (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (accept)    state_nxt = ST_EXEC;
         ST_EXEC:                state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   // Grants are withheld while reset is asserted so no accept is advertised
   always_comb begin
      req_ready = 2'b00;
      busy      = 1'b1;
      rsp_valid = 1'b0;
      unique case (state)
         ST_IDLE: begin
            req_ready = rst_n ? grant : 2'b00;
            busy      = 1'b0;
         end
         ST_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= OP_W'(OP_ADD);
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
      end else begin
         if (accept) begin
            alu_a  <= grant_id ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
            alu_b  <= grant_id ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
            alu_op <= grant_id ? req_op[OP_W +: OP_W]    : req_op[0 +: OP_W];
            rsp_id <= grant_id;
         end
         if (state == ST_EXEC) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
         end
      end
   end

`ifdef ALU_ARB_SEQ_FLAGS_EN
   // Flags track the most recent completed operation, same edge as rsp_*
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_carry <= 1'b0;
         flag_zero  <= 1'b0;
      end else if (state == ST_EXEC) begin
         flag_carry <= alu_carry;
         flag_zero  <= alu_zero;
      end
   end
`else
   assign flag_carry = 1'b0;
   assign flag_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arb_seq.sv
// Directed bench for alu_arb_seq with a behavioural ALU attached to the alu_* ports.
module tb_alu_arb_seq;

   localparam int DW = 8;
   localparam int OW = 3;
`ifdef ALU_ARB_SEQ_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [2*OW-1:0] req_op;
   logic [2*DW-1:0] req_a, req_b;
   logic            rsp_valid, rsp_ready, rsp_id;
   logic [DW-1:0]   rsp_result;
   logic            rsp_carry, rsp_zero;
   logic [DW-1:0]   alu_a, alu_b, alu_result;
   logic [OW-1:0]   alu_op;
   logic            alu_carry, alu_zero;
   logic            flag_carry, flag_zero, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arb_seq #(.DATA_W(DW), .OP_W(OW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .flag_carry(flag_carry), .flag_zero(flag_zero), .busy(busy)
   );

   // Carry is carry-out for ADD/INC and borrow for SUB/DEC
   function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} - {1'b0, b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         3'd5:    return {1'b0, ~a};
         3'd6:    return {1'b0, a} + 9'd1;
         default: return {1'b0, a} - 9'd1;
      endcase
   endfunction

   always_comb begin
      {alu_carry, alu_result} = alu_model(alu_op, alu_a, alu_b);
      alu_zero = (alu_result == '0);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      req_op[id*OW +: OW] = op;
      req_a[id*DW +: DW]  = a;
      req_b[id*DW +: DW]  = b;
      req_valid[id]       = 1'b1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      #2;
      rst_n = 1'b1;
   endtask

   // Wait for requester id's grant, then run the op to completion with rsp_ready high
   task automatic serve(input int id, input logic [7:0] er, input logic ec, input logic ez, input string tag);
      int n = 0;
      #1;
      while (!req_ready[id] && n < 8) begin
         tick();
         n++;
      end
      chk({tag, "_grant"}, req_ready, (id == 1) ? 2'b10 : 2'b01);
      tick();
      req_valid[id] = 1'b0;
      chk({tag, "_busy"}, busy, 1'b1);
      tick();
      chk({tag, "_vld"}, rsp_valid, 1'b1);
      chk({tag, "_id"}, rsp_id, id);
      chk({tag, "_res"}, rsp_result, er);
      chk({tag, "_cz"}, {rsp_carry, rsp_zero}, {ec, ez});
      tick();
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 2'b01; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      #12;
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rspv", rsp_valid, 1'b0);
      chk("rst_alu", {alu_a, alu_b, alu_op}, '0);
      chk("rst_rsp", {rsp_id, rsp_result, rsp_carry, rsp_zero}, '0);
      chk("rst_flags", {flag_carry, flag_zero}, 2'b00);
      req_valid = 2'b00;
      tick();
      rst_n = 1'b1;

      // Single ADD from requester 0, step by step
      set_req(0, 3'd0, 8'd10, 8'd5);
      rsp_ready = 1'b1;
      #1;
      chk("add_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      chk("add_exec_busy", busy, 1'b1);
      chk("add_exec_rspv", rsp_valid, 1'b0);
      chk("add_exec_alu", {alu_a, alu_b}, {8'd10, 8'd5});
      chk("add_exec_ready", req_ready, 2'b00);
      tick();
      chk("add_rspv", rsp_valid, 1'b1);
      chk("add_id", rsp_id, 1'b0);
      chk("add_res", rsp_result, 8'd15);
      chk("add_cz", {rsp_carry, rsp_zero}, 2'b00);
      tick();
      chk("add_idle_rspv", rsp_valid, 1'b0);
      chk("add_idle_busy", busy, 1'b0);
      chk("add_hold_a", alu_a, 8'd10);

      // Simultaneous requests: round-robin order after reset
      do_reset();
      set_req(0, 3'd6, 8'd255, 8'd0);
      set_req(1, 3'd1, 8'd5, 8'd10);
      serve(0, 8'd0, 1'b1, 1'b1, "rr_inc0");
      chk("flags_inc", {flag_carry, flag_zero}, FL ? 2'b11 : 2'b00);
      serve(1, 8'd251, 1'b1, 1'b0, "rr_sub1");
      chk("flags_sub", {flag_carry, flag_zero}, FL ? 2'b10 : 2'b00);
      set_req(0, 3'd0, 8'd1, 8'd1);
      set_req(1, 3'd0, 8'd2, 8'd2);
      #1;
      chk("rr_again", req_ready, 2'b01);
      serve(0, 8'd2, 1'b0, 1'b0, "rr_add0");
      serve(1, 8'd4, 1'b0, 1'b0, "rr_add1");

      // Flag register: INC 255 sets both, AND clears both
      set_req(0, 3'd6, 8'hFF, 8'h00);
      serve(0, 8'h00, 1'b1, 1'b1, "fl_inc");
      chk("flags_inc2", {flag_carry, flag_zero}, FL ? 2'b11 : 2'b00);
      set_req(0, 3'd2, 8'hCC, 8'hAA);
      serve(0, 8'h88, 1'b0, 1'b0, "fl_and");
      chk("flags_and", {flag_carry, flag_zero}, 2'b00);

      // Response backpressure with requester 1 waiting
      do_reset();
      rsp_ready = 1'b0;
      set_req(0, 3'd4, 8'h0F, 8'hFF);
      set_req(1, 3'd6, 8'hFF, 8'h00);
      #1;
      chk("bp_ready", req_ready, 2'b01);
      tick();
      req_valid[0] = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("bp_rspv", rsp_valid, 1'b1);
         chk("bp_rsp", {rsp_id, rsp_result, rsp_carry, rsp_zero}, {1'b0, 8'hF0, 2'b00});
         chk("bp_ready_lo", req_ready, 2'b00);
         chk("bp_busy", busy, 1'b1);
         chk("bp_alu", {alu_a, alu_b, alu_op}, {8'h0F, 8'hFF, 3'd4});
         tick();
      end
      chk("bp_still_vld", rsp_valid, 1'b1);
      rsp_ready = 1'b1;
      tick();
      chk("bp_done_rspv", rsp_valid, 1'b0);
      chk("bp_req1_ready", req_ready, 2'b10);
      tick();
      req_valid[1] = 1'b0;
      chk("bp_req1_acc", {busy, alu_a, alu_op}, {1'b1, 8'hFF, 3'd6});
      tick();
      chk("bp_req1_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero}, {2'b11, 8'h00, 2'b11});
      tick();
      chk("flags_pre_rst", {flag_carry, flag_zero}, FL ? 2'b11 : 2'b00);

      // Reset mid-EXEC aborts the DEC and restores the pointer
      set_req(0, 3'd7, 8'h00, 8'h55);
      #1;
      chk("ab_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      chk("ab_exec", {busy, alu_op, alu_b}, {1'b1, 3'd7, 8'h55});
      #2;
      rst_n = 1'b0;
      #1;
      chk("ab_ctrl", {rsp_valid, busy, req_ready}, 4'b0000);
      chk("ab_alu", {alu_a, alu_b, alu_op}, '0);
      chk("ab_rsp", {rsp_id, rsp_result, rsp_carry, rsp_zero}, '0);
      chk("ab_flags", {flag_carry, flag_zero}, 2'b00);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ab_no_rsp", {rsp_valid, busy}, 2'b00);
      end
      set_req(0, 3'd0, 8'd1, 8'd2);
      set_req(1, 3'd0, 8'd3, 8'd4);
      #1;
      chk("ab_ptr", req_ready, 2'b01);
      serve(0, 8'd3, 1'b0, 1'b0, "ab_add0");
      serve(1, 8'd7, 1'b0, 1'b0, "ab_add1");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
